uart_tx_serializer: RTL and testbench

- UART transmit serializer, directly downstream of the transmitter FSM.
- Accepts one byte per tx_valid and shifts it onto the serial line as 8N1, LSB first: start bit, 8 data bits, then STOP_BITS stop bits.
- Returns a one-cycle tx_done pulse that the FSM uses to pop the next FIFO entry.
- Sits between the TX FSM data register and the board TX pin.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_bit_timer.sv | 46 ++++
 rtl/uart_tx_serializer.sv | 156 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit path.
//               Optional parity support is selected with UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Default bit period: 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Level of the serial line when no frame is being sent
    localparam logic IDLE_LEVEL = 1'b1;

    // Serializer states; PARITY is only reachable when parity is compiled in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] value);
        return ^value;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module      : uart_bit_timer
// Description : Baud counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//               pulses bit_tick on the last count of each bit period.
//               Shared between the TX serializer and the future RX block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int              c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Free-running bit period counter; clear wins so each state starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bit_tick = enable && !clear && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Shifts one byte per accepted
//               tx_valid onto tx_serial, LSB first, with one start bit and
//               STOP_BITS stop bits. Pulses tx_done for one cycle after the
//               last stop bit. Define UART_TX_PARITY_EN to insert an even
//               parity bit between the data and stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       tx_serial
);

    // Bit-counter value at which the final stop bit ends
    localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_serial;
    logic       r_busy;
    logic       r_done;
`ifdef UART_TX_PARITY_EN
    logic       r_parity;
`endif

    logic w_timer_en;
    logic w_timer_clear;
    logic w_bit_tick;

    // The baud counter only runs while a frame is on the line, so every
    // frame starts from a fresh count
    assign w_timer_en    = (r_state != IDLE) && (r_state != DONE);
    assign w_timer_clear = !w_timer_en;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_timer_clear),
        .enable   (w_timer_en),
        .bit_tick (w_bit_tick)
    );

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_serial  <= IDLE_LEVEL;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts exactly like IDLE so a held tx_valid streams
                IDLE, DONE: begin
                    if (tx_valid) begin
                        r_state  <= START;
                        r_shift  <= tx_data;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= even_parity(tx_data);
`endif
                    end else begin
                        r_state  <= IDLE;
                        r_serial <= IDLE_LEVEL;
                        r_busy   <= 1'b0;
                    end
                end

                START: begin
                    if (w_bit_tick) begin
                        r_state  <= DATA;
                        r_serial <= r_shift[0];
                    end
                end

                DATA: begin
                    if (w_bit_tick) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state  <= PARITY;
                            r_serial <= r_parity;
`else
                            r_state  <= STOP;
                            r_serial <= IDLE_LEVEL;
`endif
                        end else begin
                            r_serial <= r_shift[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_tick) begin
                        r_state  <= STOP;
                        r_serial <= IDLE_LEVEL;
                    end
                end
`endif

                // The bit counter is reused to count stop bits
                STOP: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == c_last_stop) begin
                            r_state   <= DONE;
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_serial  <= IDLE_LEVEL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    r_serial  <= IDLE_LEVEL;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Directed bench for uart_tx_serializer (CLKS_PER_BIT=4).
//               Honours UART_TX_PARITY_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

    localparam int c_cpb = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_par_bits = 1;
`else
    localparam int c_par_bits = 0;
`endif

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_busy;
    logic       tx_serial;

    logic       tx_valid2;
    logic [7:0] tx_data2;
    logic       tx_done2;
    logic       tx_busy2;
    logic       tx_serial2;

    int checks = 0;
    int errors = 0;

    // Frame record: byte, hand-written line levels {stop, d7..d0, start}, parity
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs [8];

    uart_tx_serializer #(
        .CLKS_PER_BIT (c_cpb),
        .STOP_BITS    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .tx_busy   (tx_busy),
        .tx_serial (tx_serial)
    );

    uart_tx_serializer #(
        .CLKS_PER_BIT (c_cpb),
        .STOP_BITS    (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid2),
        .tx_data   (tx_data2),
        .tx_done   (tx_done2),
        .tx_busy   (tx_busy2),
        .tx_serial (tx_serial2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Expand a frame record into the sequence of bit levels on the line
    function automatic int build_levels(input logic [9:0] f, input logic p,
                                        input int sb, output logic [11:0] lv);
        int n;
        lv = '1;
        n  = 0;
        for (int i = 0; i < 9; i++) begin
            lv[n] = f[i];
            n++;
        end
        for (int i = 0; i < c_par_bits; i++) begin
            lv[n] = p;
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            lv[n] = f[9];
            n++;
        end
        return n;
    endfunction

    // Entered at the negedge of frame cycle 1; leaves at the tx_done cycle.
    // poke>0 pulses tx_valid with 0xFF in that frame cycle.
    task automatic expect_frame(input logic [9:0] f, input logic p, input int poke);
        logic [11:0] lv;
        int n;
        int idx;
        n = build_levels(f, p, 1, lv);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < c_cpb; c++) begin
                idx = b * c_cpb + c + 1;
                if (idx == poke) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'hFF;
                end else if (poke > 0 && idx == poke + 1) begin
                    tx_valid = 1'b0;
                end
                chk("serial_level", tx_serial, lv[b]);
                chk("busy_in_frame", tx_busy, 1'b1);
                chk("no_early_done", tx_done, 1'b0);
                @(negedge clk);
            end
        end
        chk("done_pulse", tx_done, 1'b1);
        chk("done_not_busy", tx_busy, 1'b0);
        chk("done_line_high", tx_serial, 1'b1);
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk("idle_serial", tx_serial, 1'b1);
            chk("idle_busy", tx_busy, 1'b0);
            chk("idle_done", tx_done, 1'b0);
            @(negedge clk);
        end
    endtask

    // Single frame with data scrambled after accept
    task automatic run_frame(input vec_t v, input int poke);
        tx_valid = 1'b1;
        tx_data  = v.data;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~v.data;
        expect_frame(v.frame, v.par, poke);
        @(negedge clk);
        check_idle(2);
    endtask

    initial begin
        logic [11:0] lv2;
        int          n2;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[4] = '{8'h3C, 10'b1_00111100_0, 1'b0};
        vecs[5] = '{8'hC3, 10'b1_11000011_0, 1'b0};
        vecs[6] = '{8'h01, 10'b1_00000001_0, 1'b1};
        vecs[7] = '{8'h80, 10'b1_10000000_0, 1'b1};

        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_valid2 = 1'b0;
        tx_data2  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_serial", tx_serial, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_serial2", tx_serial2, 1'b1);
        chk("rst_busy2", tx_busy2, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle(2);

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], 0);
        end

        // Busy ignore: 0xFF pulsed at cycle 10 of a 0x01 frame
        run_frame(vecs[6], 10);
        check_idle(c_cpb * 3);

        // Back-to-back: tx_valid held, data switched to 0xC3 mid-frame
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_data  = 8'hC3;
        expect_frame(vecs[4].frame, vecs[4].par, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        expect_frame(vecs[5].frame, vecs[5].par, 0);
        @(negedge clk);
        check_idle(3);

        // Reset during data bit 3 of 0x55
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_bit3", tx_serial, 1'b0);
        chk("pre_rst_busy", tx_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_serial", tx_serial, 1'b1);
        chk("async_rst_busy", tx_busy, 1'b0);
        chk("async_rst_done", tx_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle(c_cpb * 12);
        run_frame(vecs[2], 0);

        // Two stop bits on the second instance
        tx_valid2 = 1'b1;
        tx_data2  = 8'h80;
        @(negedge clk);
        tx_valid2 = 1'b0;
        tx_data2  = 8'h7F;
        n2 = build_levels(vecs[7].frame, vecs[7].par, 2, lv2);
        for (int b = 0; b < n2; b++) begin
            for (int c = 0; c < c_cpb; c++) begin
                chk("sb2_serial", tx_serial2, lv2[b]);
                chk("sb2_busy", tx_busy2, 1'b1);
                chk("sb2_no_early_done", tx_done2, 1'b0);
                @(negedge clk);
            end
        end
        chk("sb2_done_pulse", tx_done2, 1'b1);
        chk("sb2_done_not_busy", tx_busy2, 1'b0);
        @(negedge clk);
        chk("sb2_done_once", tx_done2, 1'b0);
        chk("sb2_idle_serial", tx_serial2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
